// File: rtl/serial_adder.sv
// Bit-serial adder: one full-add stage and a registered carry, LSB-first,
// with a start/busy/done handshake toward the controller.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} stateT;

  stateT            r_state;
  logic [WIDTH-1:0] r_aSh;
  logic [WIDTH-1:0] r_bSh;
  logic [WIDTH-1:0] r_sSh;
  logic [WIDTH-1:0] r_sum;
  logic [CW-1:0]    r_cnt;
  logic             r_c;
  logic             r_cout;
  logic             r_busy;
  logic             r_done;

  logic             w_p;
  logic             w_s;
  logic             w_cNext;
  logic [WIDTH-1:0] w_sShNext;

  // Two half-add steps: propagate, then sum with the stored carry.
  assign w_p     = r_aSh[0] ^ r_bSh[0];
  assign w_s     = w_p ^ r_c;
  assign w_cNext = (r_aSh[0] & r_bSh[0]) | (r_c & w_p);

  generate
    if (WIDTH == 1) begin : g_w1
      assign w_sShNext = w_s;
    end else begin : g_wn
      assign w_sShNext = {w_s, r_sSh[WIDTH-1:1]};
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_aSh   <= '0;
      r_bSh   <= '0;
      r_sSh   <= '0;
      r_sum   <= '0;
      r_cnt   <= '0;
      r_c     <= 1'b0;
      r_cout  <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            r_aSh   <= a;
            r_bSh   <= b;
            r_c     <= cin;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_state <= RUN;
          end
        end
        RUN: begin
          r_aSh <= r_aSh >> 1;
          r_bSh <= r_bSh >> 1;
          r_sSh <= w_sShNext;
          r_c   <= w_cNext;
          r_cnt <= r_cnt + CW'(1);
          // Last bit: publish result only now, so sum/cout never show partials.
          if (r_cnt == CW'(WIDTH - 1)) begin
            r_sum   <= w_sShNext;
            r_cout  <= w_cNext;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= DONE;
          end
        end
        DONE: begin
          r_done  <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign sum  = r_sum;
  assign cout = r_cout;

endmodule
